// File: rtl/leitor_digitos_base.sv
// leitor_digitos_base: accumulates digits entered one at a time in decimal,
// hexadecimal or octal into an 8-bit value. Each digit is checked against the
// base, the per-base digit limit and the 8-bit range. The result is committed
// to o_valor_binario on confirmar.
module leitor_digitos_base (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_digito,
    input  logic       i_digito_valido,
    input  logic [1:0] i_base_selecionada,
    input  logic       i_limpar,
    input  logic       i_confirmar,
    output logic [7:0] o_acumulador,
    output logic [1:0] o_num_digitos,
    output logic [7:0] o_valor_binario,
    output logic       o_pronto,
    output logic       o_erro
);

    typedef enum logic [1:0] {
        VAZIO    = 2'd0,
        ENTRANDO = 2'd1,
        ERRO     = 2'd2
    } estado_t;

    estado_t     r_estado;
    logic [7:0]  r_acumulador;
    logic [1:0]  r_num_digitos;
    logic [7:0]  r_valor_binario;
    logic        r_pronto;
    logic        r_erro;
    logic [1:0]  r_base;

    logic [11:0] w_acum_ext;
    logic [11:0] w_produto;
    logic [11:0] w_novo;
    logic [4:0]  w_base_valor;
    logic [1:0]  w_limite;
    logic        w_base_invalida;
    logic        w_rejeita;
    logic        w_mudou_base;

    assign w_acum_ext   = {4'd0, r_acumulador};
    assign w_mudou_base = (i_base_selecionada != r_base);

    // Per-base multiplier (shift/add only), base value and digit-count limit
    always_comb begin
        w_produto       = 12'd0;
        w_base_valor    = 5'd0;
        w_limite        = 2'd0;
        w_base_invalida = 1'b0;
        case (i_base_selecionada)
            2'b00: begin
                w_produto    = (w_acum_ext << 3) + (w_acum_ext << 1);
                w_base_valor = 5'd10;
                w_limite     = 2'd3;
            end
            2'b01: begin
                w_produto    = w_acum_ext << 4;
                w_base_valor = 5'd16;
                w_limite     = 2'd2;
            end
            2'b10: begin
                w_produto    = w_acum_ext << 3;
                w_base_valor = 5'd8;
                w_limite     = 2'd3;
            end
            default: begin
                w_base_invalida = 1'b1;
            end
        endcase
    end

    assign w_novo    = w_produto + {8'd0, i_digito};
    assign w_rejeita = w_base_invalida
                     || ({1'b0, i_digito} >= w_base_valor)
                     || (r_num_digitos == w_limite)
                     || (w_novo > 12'd255);

    // Entry state machine: clear/base change beats confirm, confirm beats a digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado        <= VAZIO;
            r_acumulador    <= 8'd0;
            r_num_digitos   <= 2'd0;
            r_valor_binario <= 8'd0;
            r_pronto        <= 1'b0;
            r_erro          <= 1'b0;
            r_base          <= 2'b00;
        end else begin
            r_base   <= i_base_selecionada;
            r_pronto <= 1'b0;
            if (i_limpar || w_mudou_base) begin
                r_estado      <= VAZIO;
                r_acumulador  <= 8'd0;
                r_num_digitos <= 2'd0;
                r_erro        <= 1'b0;
            end else if (r_estado != ERRO) begin
                if (i_confirmar) begin
                    r_valor_binario <= r_acumulador;
                    r_pronto        <= 1'b1;
                    r_acumulador    <= 8'd0;
                    r_num_digitos   <= 2'd0;
                    r_estado        <= VAZIO;
                end else if (i_digito_valido) begin
                    if (w_rejeita) begin
                        r_estado <= ERRO;
                        r_erro   <= 1'b1;
                    end else begin
                        r_acumulador  <= w_novo[7:0];
                        r_num_digitos <= r_num_digitos + 2'd1;
                        r_estado      <= ENTRANDO;
                    end
                end
            end
        end
    end

    assign o_acumulador    = r_acumulador;
    assign o_num_digitos   = r_num_digitos;
    assign o_valor_binario = r_valor_binario;
    assign o_pronto        = r_pronto;
    assign o_erro          = r_erro;

endmodule

// File: tb/tb_leitor_digitos_base.sv
// Directed testbench for leitor_digitos_base. Inputs change on the falling
// edge and outputs are sampled on the falling edge after each rising edge.
module tb_leitor_digitos_base;

    logic       clk;
    logic       rst_n;
    logic [3:0] i_digito;
    logic       i_digito_valido;
    logic [1:0] i_base_selecionada;
    logic       i_limpar;
    logic       i_confirmar;
    logic [7:0] o_acumulador;
    logic [1:0] o_num_digitos;
    logic [7:0] o_valor_binario;
    logic       o_pronto;
    logic       o_erro;

    int nChecks = 0;
    int nPass   = 0;

    leitor_digitos_base dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_digito           (i_digito),
        .i_digito_valido    (i_digito_valido),
        .i_base_selecionada (i_base_selecionada),
        .i_limpar           (i_limpar),
        .i_confirmar        (i_confirmar),
        .o_acumulador       (o_acumulador),
        .o_num_digitos      (o_num_digitos),
        .o_valor_binario    (o_valor_binario),
        .o_pronto           (o_pronto),
        .o_erro             (o_erro)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle digit strobe; returns at the next falling edge
    task automatic digit(input logic [3:0] d);
        i_digito        = d;
        i_digito_valido = 1'b1;
        @(negedge clk);
        i_digito_valido = 1'b0;
    endtask

    task automatic confirm();
        i_confirmar = 1'b1;
        @(negedge clk);
        i_confirmar = 1'b0;
    endtask

    task automatic clearEntry();
        i_limpar = 1'b1;
        @(negedge clk);
        i_limpar = 1'b0;
    endtask

    task automatic setBase(input logic [1:0] b);
        i_base_selecionada = b;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_digito = 4'd0;
        i_digito_valido = 1'b0;
        i_base_selecionada = 2'b00;
        i_limpar = 1'b0;
        i_confirmar = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        nChecks++;
        if ({o_acumulador, o_num_digitos, o_valor_binario, o_pronto, o_erro} !== 20'd0)
            $display("[TB] FAIL reset_state: got acc=%0d n=%0d val=%0d pronto=%b erro=%b, expected all 0",
                     o_acumulador, o_num_digitos, o_valor_binario, o_pronto, o_erro);
        else nPass++;
    endtask

    task automatic test_decimal_max();
        digit(4'd2);
        nChecks++;
        if (o_acumulador !== 8'd2) $display("[TB] FAIL dec_step1: acc=%0d expected 2", o_acumulador);
        else nPass++;
        digit(4'd5);
        nChecks++;
        if (o_acumulador !== 8'd25 || o_num_digitos !== 2'd2)
            $display("[TB] FAIL dec_step2: acc=%0d n=%0d expected 25/2", o_acumulador, o_num_digitos);
        else nPass++;
        digit(4'd5);
        nChecks++;
        if (o_acumulador !== 8'd255 || o_num_digitos !== 2'd3 || o_erro !== 1'b0)
            $display("[TB] FAIL dec_step3: acc=%0d n=%0d erro=%b expected 255/3/0",
                     o_acumulador, o_num_digitos, o_erro);
        else nPass++;
        confirm();
        nChecks++;
        if (o_valor_binario !== 8'd255 || o_pronto !== 1'b1 || o_acumulador !== 8'd0 || o_num_digitos !== 2'd0)
            $display("[TB] FAIL dec_commit: val=%0d pronto=%b acc=%0d n=%0d expected 255/1/0/0",
                     o_valor_binario, o_pronto, o_acumulador, o_num_digitos);
        else nPass++;
        @(negedge clk);
        nChecks++;
        if (o_pronto !== 1'b0) $display("[TB] FAIL dec_pronto_pulse: pronto=%b expected 0", o_pronto);
        else nPass++;
    endtask

    task automatic test_decimal_overflow();
        digit(4'd2);
        digit(4'd5);
        digit(4'd6);
        nChecks++;
        if (o_erro !== 1'b1 || o_acumulador !== 8'd25 || o_num_digitos !== 2'd2)
            $display("[TB] FAIL dec_overflow: erro=%b acc=%0d n=%0d expected 1/25/2",
                     o_erro, o_acumulador, o_num_digitos);
        else nPass++;
        confirm();
        nChecks++;
        if (o_pronto !== 1'b0 || o_valor_binario !== 8'd255 || o_erro !== 1'b1)
            $display("[TB] FAIL err_confirm_ignored: pronto=%b val=%0d erro=%b expected 0/255/1",
                     o_pronto, o_valor_binario, o_erro);
        else nPass++;
        digit(4'd1);
        nChecks++;
        if (o_acumulador !== 8'd25 || o_erro !== 1'b1)
            $display("[TB] FAIL err_digit_ignored: acc=%0d erro=%b expected 25/1", o_acumulador, o_erro);
        else nPass++;
        clearEntry();
        nChecks++;
        if (o_erro !== 1'b0 || o_acumulador !== 8'd0 || o_num_digitos !== 2'd0 || o_valor_binario !== 8'd255)
            $display("[TB] FAIL limpar_exit_err: erro=%b acc=%0d n=%0d val=%0d expected 0/0/0/255",
                     o_erro, o_acumulador, o_num_digitos, o_valor_binario);
        else nPass++;
        digit(4'd9);
        nChecks++;
        if (o_acumulador !== 8'd9 || o_erro !== 1'b0)
            $display("[TB] FAIL dec_after_clear: acc=%0d erro=%b expected 9/0", o_acumulador, o_erro);
        else nPass++;
        digit(4'hA);
        nChecks++;
        if (o_erro !== 1'b1 || o_acumulador !== 8'd9)
            $display("[TB] FAIL dec_bad_digit: erro=%b acc=%0d expected 1/9", o_erro, o_acumulador);
        else nPass++;
    endtask

    task automatic test_hex();
        setBase(2'b01);
        nChecks++;
        if (o_erro !== 1'b0 || o_acumulador !== 8'd0)
            $display("[TB] FAIL base_change_exit_err: erro=%b acc=%0d expected 0/0", o_erro, o_acumulador);
        else nPass++;
        digit(4'hA);
        digit(4'hF);
        nChecks++;
        if (o_acumulador !== 8'd175) $display("[TB] FAIL hex_acc: acc=%0d expected 175", o_acumulador);
        else nPass++;
        confirm();
        nChecks++;
        if (o_valor_binario !== 8'd175 || o_pronto !== 1'b1)
            $display("[TB] FAIL hex_commit: val=%0d pronto=%b expected 175/1", o_valor_binario, o_pronto);
        else nPass++;
        digit(4'd1);
        digit(4'd2);
        nChecks++;
        if (o_erro !== 1'b0 || o_acumulador !== 8'h12)
            $display("[TB] FAIL hex_two_digits: erro=%b acc=%0d expected 0/18", o_erro, o_acumulador);
        else nPass++;
        digit(4'd3);
        nChecks++;
        if (o_erro !== 1'b1 || o_acumulador !== 8'h12 || o_num_digitos !== 2'd2)
            $display("[TB] FAIL hex_limit: erro=%b acc=%0d n=%0d expected 1/18/2",
                     o_erro, o_acumulador, o_num_digitos);
        else nPass++;
    endtask

    task automatic test_octal();
        setBase(2'b10);
        digit(4'd3);
        digit(4'd7);
        digit(4'd7);
        nChecks++;
        if (o_acumulador !== 8'd255 || o_erro !== 1'b0)
            $display("[TB] FAIL oct_acc: acc=%0d erro=%b expected 255/0", o_acumulador, o_erro);
        else nPass++;
        confirm();
        nChecks++;
        if (o_valor_binario !== 8'd255 || o_pronto !== 1'b1)
            $display("[TB] FAIL oct_commit: val=%0d pronto=%b expected 255/1", o_valor_binario, o_pronto);
        else nPass++;
        digit(4'd8);
        nChecks++;
        if (o_erro !== 1'b1 || o_num_digitos !== 2'd0)
            $display("[TB] FAIL oct_digit8: erro=%b n=%0d expected 1/0", o_erro, o_num_digitos);
        else nPass++;
        clearEntry();
        digit(4'd4);
        digit(4'd0);
        nChecks++;
        if (o_acumulador !== 8'd32 || o_erro !== 1'b0)
            $display("[TB] FAIL oct_40: acc=%0d erro=%b expected 32/0", o_acumulador, o_erro);
        else nPass++;
        digit(4'd0);
        nChecks++;
        if (o_erro !== 1'b1 || o_acumulador !== 8'd32)
            $display("[TB] FAIL oct_range: erro=%b acc=%0d expected 1/32", o_erro, o_acumulador);
        else nPass++;
        clearEntry();
    endtask

    task automatic test_base_change();
        setBase(2'b11);
        digit(4'd1);
        nChecks++;
        if (o_erro !== 1'b1) $display("[TB] FAIL invalid_base: erro=%b expected 1", o_erro);
        else nPass++;
        setBase(2'b00);
        digit(4'd1);
        digit(4'd2);
        nChecks++;
        if (o_acumulador !== 8'd12) $display("[TB] FAIL bc_prefix: acc=%0d expected 12", o_acumulador);
        else nPass++;
        i_base_selecionada = 2'b01;
        digit(4'd3);
        nChecks++;
        if (o_acumulador !== 8'd0 || o_num_digitos !== 2'd0 || o_valor_binario !== 8'd255 || o_erro !== 1'b0)
            $display("[TB] FAIL base_change: acc=%0d n=%0d val=%0d erro=%b expected 0/0/255/0",
                     o_acumulador, o_num_digitos, o_valor_binario, o_erro);
        else nPass++;
    endtask

    task automatic test_async_reset();
        setBase(2'b00);
        digit(4'd1);
        digit(4'd2);
        #2;
        rst_n = 1'b0;
        #1;
        nChecks++;
        if ({o_acumulador, o_num_digitos, o_valor_binario, o_pronto, o_erro} !== 20'd0)
            $display("[TB] FAIL async_reset: acc=%0d n=%0d val=%0d pronto=%b erro=%b expected all 0",
                     o_acumulador, o_num_digitos, o_valor_binario, o_pronto, o_erro);
        else nPass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_limpar_confirmar();
        digit(4'd4);
        digit(4'd2);
        i_limpar = 1'b1;
        confirm();
        i_limpar = 1'b0;
        nChecks++;
        if (o_pronto !== 1'b0 || o_acumulador !== 8'd0 || o_valor_binario !== 8'd0)
            $display("[TB] FAIL limpar_confirmar: pronto=%b acc=%0d val=%0d expected 0/0/0",
                     o_pronto, o_acumulador, o_valor_binario);
        else nPass++;
    endtask

    task automatic test_back_to_back();
        digit(4'd4);
        digit(4'd2);
        i_confirmar = 1'b1;
        digit(4'd7);
        i_confirmar = 1'b0;
        nChecks++;
        if (o_valor_binario !== 8'd42 || o_pronto !== 1'b1 || o_acumulador !== 8'd0 || o_num_digitos !== 2'd0)
            $display("[TB] FAIL confirm_digit: val=%0d pronto=%b acc=%0d n=%0d expected 42/1/0/0",
                     o_valor_binario, o_pronto, o_acumulador, o_num_digitos);
        else nPass++;
        @(negedge clk);
        nChecks++;
        if (o_pronto !== 1'b0 || o_acumulador !== 8'd0)
            $display("[TB] FAIL confirm_digit_after: pronto=%b acc=%0d expected 0/0", o_pronto, o_acumulador);
        else nPass++;
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_decimal_max();
        test_decimal_overflow();
        test_hex();
        test_octal();
        test_base_change();
        test_async_reset();
        test_limpar_confirmar();
        test_back_to_back();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/leitor_digitos_base.md
# leitor_digitos_base

Sequential digit-entry reader that takes digits one at a time in a selected base (decimal, hexadecimal, octal) and accumulates them into an 8-bit binary value. It is the input-side counterpart of the binary-to-display base converter. Keypad/switch logic feeds it digits, and the committed `valor_binario` drives the ALU operand path and the display converter. It checks each digit against the base, enforces the per-base digit-count limit and the 8-bit range, and flags errors.

## Interface
- No parameters; width fixed at 8 bits.
- `clk`  input  1  system clock, rising-edge active.
- `rst_n`  input  1  asynchronous, active-low reset.
- `digito`  input  4  digit value, 0–15.
- `digito_valido`  input  1  single-cycle strobe; each high cycle offers one digit.
- `base_selecionada`  input  2  00 = decimal, 01 = hexadecimal, 10 = octal, 11 = invalid.
- `limpar`  input  1  synchronous clear of the entry in progress.
- `confirmar`  input  1  single-cycle strobe; commits the accumulator.
- `acumulador`  output  8  value entered so far.
- `num_digitos`  output  2  count of digits accepted, 0–3.
- `valor_binario`  output  8  last committed value.
- `pronto`  output  1  one-cycle pulse when `valor_binario` updates.
- `erro`  output  1  high while in state ERRO.

## Operation
- **States:**
  - VAZIO: no digits entered.
  - ENTRANDO: at least one digit accepted.
  - ERRO: entry rejected.
- **Base value B and digit limit L:**
  - Decimal: B = 10, L = 3.
  - Hexadecimal: B = 16, L = 2.
  - Octal: B = 8, L = 3.
  - Base 11: no valid base.
- **Accepting a digit (state VAZIO or ENTRANDO, `digito_valido` = 1):**
  - Compute `novo = acumulador*B + digito` in 12 bits, using shifts and adds only:
    - ×10 = (x<<3) + (x<<1).
    - ×16 = x<<4.
    - ×8 = x<<3.
  - Reject the digit if any of these holds: `digito` ≥ B, base = 11, `num_digitos` = L, or `novo` > 255.
  - On reject: go to ERRO, leave `acumulador` and `num_digitos` unchanged, raise `erro`.
  - Otherwise: `acumulador` ← `novo[7:0]`, `num_digitos` increments, state goes to ENTRANDO.
- **In ERRO:**
  - `digito_valido` and `confirmar` are ignored.
  - Only `limpar`, a base change, or reset exit ERRO.
- **`confirmar` in VAZIO or ENTRANDO:**
  - `valor_binario` ← `acumulador` (0 when in VAZIO).
  - `pronto` pulses.
  - `acumulador` and `num_digitos` clear; state goes to VAZIO.
- **`limpar` in any state:**
  - `acumulador`, `num_digitos` and `erro` clear; state goes to VAZIO.
  - `valor_binario` is not changed.
- **Base change** (`base_selecionada` differs from the value registered on the previous cycle): same effect as `limpar`. Any `digito_valido` or `confirmar` in that same cycle is discarded.
- **Priority within one cycle:** reset > `limpar` / base change > `confirmar` > `digito_valido`. When `confirmar` and `digito_valido` coincide, the digit is dropped.

## Timing
- **Reset values:**
  - `acumulador` = 0, `num_digitos` = 0, `valor_binario` = 0.
  - `pronto` = 0, `erro` = 0, state = VAZIO.
  - Registered base = 00.
- **Reset is asynchronous:** outputs go to their reset values immediately when `rst_n` falls, including in the middle of an entry. Release is sampled on the next rising edge.
- **Digit strobe:** `acumulador`, `num_digitos` and `erro` reflect the digit on the first rising edge after the strobe cycle (1-cycle latency).
- **Commit:** `valor_binario` updates and `pronto` is high in the cycle after the `confirmar` cycle, for exactly one cycle.
- **Back-to-back strobes:** accepted on consecutive cycles, with no wait states.
- **Registered outputs:** all outputs come from registers; there is no combinational path from inputs to outputs.

## Test plan
- **Decimal, maximum value:** base 00, digits 2, 5, 5, then `confirmar`. Required: `acumulador` steps 2 → 25 → 255; next cycle `valor_binario` = 255, `pronto` high for 1 cycle, `acumulador` = 0.
- **Decimal overflow:** base 00, digits 2, 5, 6. Required: `erro` = 1 and `acumulador` stays 25. A following `confirmar` gives no `pronto` and leaves `valor_binario` unchanged. `limpar` then gives `erro` = 0, state VAZIO.
- **Hex entry and hex digit limit:** base 01, digits A, F, then `confirmar`. Required: `valor_binario` = 175. A second entry of digits 1, 2, 3 sets `erro` on the third digit with `acumulador` = 0x12.
- **Octal range checks:**
  - Base 10, digits 3, 7, 7, then `confirmar`: required `valor_binario` = 255.
  - Digit 8 entered in octal: `erro` immediately.
  - Digits 4, 0, 0 (value 256): `erro` on the third digit.
- **Base change mid-entry:** base 00, digits 1, 2; switch to base 01 in the same cycle as a strobe for digit 3. Required: `acumulador` = 0, `num_digitos` = 0, digit dropped, `valor_binario` unchanged.
- **Reset and simultaneous events:**
  - `rst_n` low mid-entry asynchronously clears all outputs.
  - `limpar` together with `confirmar`: no `pronto`.
  - `confirmar` together with `digito_valido` 7 after digits 4, 2: `valor_binario` = 42, digit dropped.
